// File: rtl/if_pkg.sv
// Shared types for the fetch stage: BHT counter encoding, BTB entry layout, NOP constant.
package if_pkg;

    typedef enum logic [1:0] {
        Snt = 2'b00,
        Wnt = 2'b01,
        Wt  = 2'b10,
        St  = 2'b11
    } bht_ctr_e;

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    // Wide enough for the tag of the smallest table (pc[31:2]); narrower tags are zero-extended.
    localparam int unsigned TagW = 30;

    typedef struct packed {
        logic            valid;
        logic [TagW-1:0] tag;
        logic [31:0]     target;
    } btb_entry_t;

    function automatic bht_ctr_e ctr_next(input bht_ctr_e c, input logic taken);
        if (taken) begin
            return (c == St) ? St : bht_ctr_e'(c + 2'd1);
        end
        return (c == Snt) ? Snt : bht_ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// 2-bit saturating BHT plus direct-mapped BTB; only built when BRANCH_PRED_EN is defined.
`ifdef BRANCH_PRED_EN
module bht_2bit
    import if_pkg::*;
#(
    parameter int unsigned Entries = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lookup_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i
);

    localparam int unsigned IdxW = $clog2(Entries);

    bht_ctr_e   ctr_q [Entries];
    btb_entry_t btb_q [Entries];

    logic [IdxW-1:0] lk_idx;
    logic [IdxW-1:0] up_idx;
    logic [TagW-1:0] lk_tag;
    logic [TagW-1:0] up_tag;
    btb_entry_t      lk_entry;
    logic            unused_lsb;

    assign lk_idx = lookup_pc_i[IdxW+1:2];
    assign up_idx = upd_pc_i[IdxW+1:2];
    assign lk_tag = TagW'(lookup_pc_i >> (IdxW + 2));
    assign up_tag = TagW'(upd_pc_i >> (IdxW + 2));
    assign unused_lsb = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    // Reads see the pre-update state when lookup and update share an index.
    assign lk_entry      = btb_q[lk_idx];
    assign pred_taken_o  = lk_entry.valid && (lk_entry.tag == lk_tag) && ctr_q[lk_idx][1];
    assign pred_target_o = lk_entry.target;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < Entries; i++) begin
                ctr_q[i] <= Wnt;
                btb_q[i] <= '0;
            end
        end else if (upd_valid_i) begin
            ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken_i);
            if (upd_taken_i) begin
                btb_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target_i};
            end
        end
    end

endmodule
`endif

// File: rtl/if_stage.sv
// Instruction fetch: PC select, optional BHT/BTB prediction (BRANCH_PRED_EN), IF/ID register.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic [31:0] o_pc_fetch,
    input  logic [31:0] i_instr,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr,
    output logic        o_if_valid,
    output logic        o_if_pred_taken,
    input  logic        i_ex_br_valid,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_mispredict,
    input  logic [31:0] i_ex_redirect_pc
);

    localparam logic [31:0] PcMask = 32'hFFFF_FFFC;

    logic [31:0] pc_q, pc_d;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        bubble;

`ifdef BRANCH_PRED_EN
    bht_2bit #(
        .Entries(BHT_ENTRIES)
    ) u_bht (
        .clk_i        (i_clk),
        .rst_ni       (i_rst_n),
        .lookup_pc_i  (pc_q),
        .pred_taken_o (pred_taken),
        .pred_target_o(pred_target),
        .upd_valid_i  (i_ex_br_valid),
        .upd_pc_i     (i_ex_pc),
        .upd_taken_i  (i_ex_taken),
        .upd_target_i (i_ex_target)
    );
`else
    logic unused_ex;
    assign pred_taken  = 1'b0;
    assign pred_target = '0;
    assign unused_ex   = ^{i_ex_br_valid, i_ex_pc, i_ex_taken, i_ex_target, 32'(BHT_ENTRIES)};
`endif

    assign bubble     = i_flush | i_ex_mispredict;
    assign o_pc_fetch = pc_q;

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (i_ex_mispredict) begin
            pc_d = i_ex_redirect_pc & PcMask;
        end else if (i_stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target & PcMask;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc_q            <= RESET_PC & PcMask;
            o_if_pc         <= '0;
            o_if_instr      <= NopInstr;
            o_if_valid      <= 1'b0;
            o_if_pred_taken <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (bubble) begin
                o_if_instr      <= NopInstr;
                o_if_valid      <= 1'b0;
                o_if_pred_taken <= 1'b0;
            end else if (!i_stall) begin
                o_if_pc         <= pc_q;
                o_if_instr      <= i_instr;
                o_if_valid      <= 1'b1;
                o_if_pred_taken <= pred_taken;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; expectations follow BRANCH_PRED_EN when it is defined.
module tb_if_stage;
    import if_pkg::*;

`ifdef BRANCH_PRED_EN
    localparam bit PredEn = 1'b1;
`else
    localparam bit PredEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall, flush, misp, br_valid, ex_taken;
    logic [31:0] redir, instr, ex_pc, ex_target;
    logic [31:0] pc_fetch, if_pc, if_instr;
    logic        if_valid, if_pred;

    int total = 0;
    int bad   = 0;

    if_stage #(
        .RESET_PC   (32'h0000_0000),
        .BHT_ENTRIES(64)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_stall         (stall),
        .i_flush         (flush),
        .o_pc_fetch      (pc_fetch),
        .i_instr         (instr),
        .o_if_pc         (if_pc),
        .o_if_instr      (if_instr),
        .o_if_valid      (if_valid),
        .o_if_pred_taken (if_pred),
        .i_ex_br_valid   (br_valid),
        .i_ex_pc         (ex_pc),
        .i_ex_taken      (ex_taken),
        .i_ex_target     (ex_target),
        .i_ex_mispredict (misp),
        .i_ex_redirect_pc(redir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        misp;
        logic [31:0] redir;
        logic [31:0] instr;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic [31:0] exp_if_pc;
        logic [31:0] exp_if_instr;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic redirect(input logic [31:0] addr);
        misp  = 1'b1;
        redir = addr;
        step();
        misp  = 1'b0;
    endtask

    task automatic ex_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        stall     = 1'b1;
        br_valid  = 1'b1;
        ex_pc     = pc;
        ex_taken  = taken;
        ex_target = tgt;
        step();
        br_valid  = 1'b0;
        stall     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; misp = 1'b0; br_valid = 1'b0;
        ex_taken = 1'b0; redir = '0; instr = '0; ex_pc = '0; ex_target = '0;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hA0, 32'h4,         1'b1, 32'h0,         32'hA0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hA1, 32'h8,         1'b1, 32'h4,         32'hA1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'hA2, 32'hC,         1'b0, 32'h0,         NopInstr};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'hB3, 32'hC,         1'b0, 32'h0,         NopInstr};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hA4, 32'h10,        1'b1, 32'hC,         32'hA4};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h101,       32'hA5, 32'h100,       1'b0, 32'h0,         NopInstr};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h200,       32'hA6, 32'h200,       1'b0, 32'h0,         NopInstr};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hA7, 32'h204,       1'b1, 32'h200,       32'hA7};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'hA8, 32'hFFFF_FFFC, 1'b0, 32'h0,         NopInstr};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hA9, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'hA9};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'hAA, 32'h0,         1'b0, 32'h0,         NopInstr};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hAB, 32'h4,         1'b1, 32'h0,         32'hAB};

        // Reset for two edges, then check the reset image before the first fetch edge.
        step();
        step();
        rst_n = 1'b1;
        chk("reset_pc", pc_fetch, 32'h0);
        chk("reset_valid", {31'b0, if_valid}, 32'h0);
        chk("reset_if_pc", if_pc, 32'h0);
        chk("reset_if_instr", if_instr, NopInstr);
        chk("reset_pred", {31'b0, if_pred}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            stall = vecs[i].stall;
            flush = vecs[i].flush;
            misp  = vecs[i].misp;
            redir = vecs[i].redir;
            instr = vecs[i].instr;
            step();
            chk($sformatf("vec%0d_pc", i), pc_fetch, vecs[i].exp_pc);
            chk($sformatf("vec%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_instr", i), if_instr, vecs[i].exp_if_instr);
            chk($sformatf("vec%0d_pred", i), {31'b0, if_pred}, 32'h0);
            if (vecs[i].exp_valid) chk($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].exp_if_pc);
        end
        stall = 1'b0; flush = 1'b0; misp = 1'b0;

        // Stall hold at PC 0x10 with a valid word in IF/ID.
        redirect(32'hC);
        instr = 32'hC0;
        step();
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            instr = 32'hE00 + 32'(i);
            step();
            chk($sformatf("stall%0d_pc", i), pc_fetch, 32'h10);
            chk($sformatf("stall%0d_if_pc", i), if_pc, 32'hC);
            chk($sformatf("stall%0d_instr", i), if_instr, 32'hC0);
            chk($sformatf("stall%0d_valid", i), {31'b0, if_valid}, 32'h1);
        end
        stall = 1'b0;
        instr = 32'hD0;
        step();
        chk("stall_release_pc", pc_fetch, 32'h14);
        chk("stall_release_if_pc", if_pc, 32'h10);

        // Train 0x40 -> 0x100 twice (WNT -> WT -> ST) while the front end is stalled.
        ex_update(32'h40, 1'b1, 32'h100);
        ex_update(32'h40, 1'b1, 32'h100);
        chk("train_stall_pc", pc_fetch, 32'h14);
        redirect(32'h40);
        instr = 32'hE0;
        step();
        chk("train_next_pc", pc_fetch, PredEn ? 32'h100 : 32'h44);
        chk("train_if_pc", if_pc, 32'h40);
        chk("train_pred", {31'b0, if_pred}, {31'b0, PredEn});

        // 0x140 shares the index with 0x40 but not the tag.
        redirect(32'h140);
        step();
        chk("alias_next_pc", pc_fetch, 32'h144);
        chk("alias_pred", {31'b0, if_pred}, 32'h0);

        // Hysteresis: ST -> WT still taken, WT -> WNT falls through.
        ex_update(32'h40, 1'b0, 32'h0);
        redirect(32'h40);
        step();
        chk("hyst1_next_pc", pc_fetch, PredEn ? 32'h100 : 32'h44);
        ex_update(32'h40, 1'b0, 32'h0);
        redirect(32'h40);
        step();
        chk("hyst2_next_pc", pc_fetch, 32'h44);
        chk("hyst2_pred", {31'b0, if_pred}, 32'h0);

        // Reset overrides stall, flush, redirect and a taken update.
        rst_n = 1'b0; stall = 1'b1; flush = 1'b1; misp = 1'b1; redir = 32'h300;
        br_valid = 1'b1; ex_pc = 32'h40; ex_taken = 1'b1; ex_target = 32'h80;
        step();
        chk("rst2_pc", pc_fetch, 32'h0);
        chk("rst2_valid", {31'b0, if_valid}, 32'h0);
        chk("rst2_if_pc", if_pc, 32'h0);
        chk("rst2_instr", if_instr, NopInstr);
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0; misp = 1'b0; br_valid = 1'b0;
        instr = 32'hF0;
        step();
        chk("rst2_first_pc", pc_fetch, 32'h4);
        chk("rst2_first_valid", {31'b0, if_valid}, 32'h1);
        redirect(32'h40);
        step();
        chk("rst2_ctr_reset", pc_fetch, 32'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter BHT_ENTRIES, default 64 (power of 2): number of BHT/BTB entries, indexed by pc[log2(BHT_ENTRIES)+1:2].
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port i_stall  input  1  hold PC and IF/ID register.
REQ-006 SHALL have port i_flush  input  1  load bubble into IF/ID.
REQ-007 SHALL have port o_pc_fetch  output  32  current PC; drives the instruction memory address.
REQ-008 SHALL have port i_instr  input  32  word returned combinationally for o_pc_fetch.
REQ-009 SHALL have ports o_if_pc  output  32, o_if_instr  output  32, o_if_valid  output  1, o_if_pred_taken  output  1: the IF/ID register.
REQ-010 SHALL have ports i_ex_br_valid  input  1, i_ex_pc  input  32, i_ex_taken  input  1, i_ex_target  input  32: resolved branch/jump from EX.
REQ-011 SHALL have ports i_ex_mispredict  input  1, i_ex_redirect_pc  input  32: redirect request with the correct next PC.

Function
REQ-012 SHALL compute next PC with priority: i_ex_mispredict -> i_ex_redirect_pc; else i_stall -> hold; else prediction taken -> BTB target; else PC+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
REQ-013 SHALL force bits [1:0] of every loaded PC to 0.
REQ-014 SHALL predict taken only when the BTB entry is valid, its tag (pc[31:idx_msb+1]) matches and BHT counter bit[1] = 1.
REQ-015 SHALL perform lookup combinationally on o_pc_fetch; zero-cycle prediction latency.
REQ-016 SHALL keep each BHT counter as a 2-bit saturating FSM: SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11); taken increments, not-taken decrements, saturating at 11/00.
REQ-017 SHALL update the counter at index(i_ex_pc) on the clock edge when i_ex_br_valid=1; when i_ex_taken=1 also write BTB target=i_ex_target, tag, valid=1.
REQ-018 SHALL, when lookup and update hit the same index in one cycle, return the pre-update value (no bypass).
REQ-019 SHALL, per cycle, load IF/ID with {o_pc_fetch, i_instr, valid=1, pred_taken} unless held or bubbled.
REQ-020 SHALL bubble IF/ID (o_if_valid=0, o_if_instr=32'h0000_0013 NOP) when i_flush=1 or i_ex_mispredict=1; bubble beats i_stall.
REQ-021 SHALL hold IF/ID unchanged when i_stall=1 and no bubble; BHT/BTB updates still occur during stall.

Reset
REQ-022 SHALL, on clock edge with i_rst_n=0: PC=RESET_PC, o_if_valid=0, o_if_pc=0, o_if_instr=NOP, o_if_pred_taken=0, all counters=WNT, all BTB valid=0.
REQ-023 SHALL let reset override stall, flush, redirect and updates; first fetch at RESET_PC on the first edge after deassertion.

Configuration
REQ-024 SHALL, with BRANCH_PRED_EN defined, implement BHT/BTB as above.
REQ-025 SHALL, without BRANCH_PRED_EN, omit BHT/BTB storage, predict not-taken always (o_if_pred_taken=0, next PC=PC+4 unless redirect/stall), and ignore i_ex_br_valid.

Structure
REQ-026 SHALL place in shared package if_pkg: 2-bit counter enum (SNT/WNT/WT/ST), NOP constant 32'h0000_0013, BTB entry struct {valid, tag, target}.
REQ-027 SHALL implement counter array plus update logic as sub-module bht_2bit; PC mux and IF/ID register stay in if_stage.

Verification
REQ-028 SHALL verify reset: i_rst_n=0 two cycles, release -> o_pc_fetch=0, then 4, 8; o_if_valid=0 first cycle after reset, then 1.
REQ-029 SHALL verify training: update pc=0x40 taken target 0x100 twice -> next fetch at 0x40 gives next PC 0x100, o_if_pred_taken=1.
REQ-030 SHALL verify hysteresis: from ST at 0x40, one not-taken update -> still predicted taken; second -> PC+4 (0x44).
REQ-031 SHALL verify priority: i_stall=1 and i_ex_mispredict=1 with redirect 0x200 -> PC=0x200, o_if_valid=0 next cycle.
REQ-032 SHALL verify stall hold: i_stall=1 for 3 cycles at PC 0x10 -> o_pc_fetch and IF/ID unchanged; release -> 0x14.
REQ-033 SHALL verify aliasing: BTB trained at 0x40, fetch 0x140 (same index, BHT_ENTRIES=64) -> tag miss, next PC 0x144.
